fmap_stream_tx: RTL and testbench

- Frame-buffered pixel transmitter that drives the raster-order pixel stream (valid + data, no back-pressure wire) consumed by the conv2d/line-buffer blocks.
- Holds one IMG_WIDTH x IMG_HEIGHT feature map in internal RAM, loaded through a simple write port.
- On start, replays the map in raster order, then appends PAD_PIXELS zero pixels. The padding flushes the consumer's line buffers and valid-delay chain.
- Sits between the layer controller / loader and the first conv stage.

---
 rtl/fmap_stream_tx.sv | 180 ++++++++++++++++++
 tb/tb_fmap_stream_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx
//   Frame-buffered raster pixel transmitter. Holds one IMG_WIDTH x IMG_HEIGHT
//   feature map in an internal RAM, loaded through a simple write port while
//   idle. On start it replays the map in raster order and then appends
//   PAD_PIXELS zero pixels to flush the downstream line buffers and
//   valid-delay chain. The stream is valid + data only, with no back-pressure.
//   Issue can be paused with stall.
//
// Ports
//   clk            : clock, rising edge
//   resetn         : asynchronous active-low reset
//   wr_en          : RAM write strobe (honoured only while idle)
//   wr_addr        : raster write index row*IMG_WIDTH+col (out-of-range dropped)
//   wr_data        : RAM write data
//   start          : begin one frame (ignored while busy)
//   stall          : pause issue of new pixels; in-flight pixels still emerge
//   busy           : frame, flush or completion in progress
//   data_valid_out : pixel valid
//   data_out       : pixel data (holds its last value while not valid)
//   frame_last     : high with the last image pixel (index W*H-1)
//   done           : one-cycle pulse after the last output pixel
//
// Timing: a pixel issued in cycle t appears on the outputs in cycle t+2. The
// first stage is the synchronous RAM read; the second is the output register.

module fmap_stream_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter int PAD_PIXELS = IMG_WIDTH + 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic                  data_valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_last,
  output logic                  done
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  // The pad counter keeps at least one bit so that a PAD_PIXELS=0 build
  // still elaborates; the FLUSH phase is skipped entirely in that case.
  localparam int PAD_W = (PAD_PIXELS > 0) ? $clog2(PAD_PIXELS + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(NPIX - 1);
  localparam logic [PAD_W-1:0]      PAD_LAST =
    PAD_W'((PAD_PIXELS > 0) ? PAD_PIXELS - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_FIN    = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [PAD_W-1:0]      pad_cnt;

  // Frame store and its synchronous read register
  logic [DATA_WIDTH-1:0] mem [NPIX];
  logic [DATA_WIDTH-1:0] rd_data;

  // Stage-1 tags travelling alongside the RAM read
  logic s1_valid;
  logic s1_pad;
  logic s1_last;

  logic issue;
  logic issue_pix;
  logic wr_ok;

  always_comb begin
    issue_pix = 1'b0;
    issue     = 1'b0;
    wr_ok     = 1'b0;
    if (state == S_STREAM && !stall) begin
      issue_pix = 1'b1;
    end
    if ((state == S_STREAM || state == S_FLUSH) && !stall) begin
      issue = 1'b1;
    end
    if (wr_en && state == S_IDLE && (32'(wr_addr) < 32'(NPIX))) begin
      wr_ok = 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

  // RAM: no reset on contents or the read register. The read register is
  // only ever consumed under s1_valid, which does reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (issue_pix) begin
      rd_data <= mem[pix_cnt];
    end
  end

  // Control FSM and counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pix_cnt <= '0;
      pad_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_STREAM;
            pix_cnt <= '0;
          end
        end
        S_STREAM: begin
          if (!stall) begin
            if (pix_cnt == PIX_LAST) begin
              pix_cnt <= '0;
              pad_cnt <= '0;
              state   <= (PAD_PIXELS > 0) ? S_FLUSH : S_FIN;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (!stall) begin
            if (pad_cnt == PAD_LAST) begin
              pad_cnt <= '0;
              state   <= S_FIN;
            end else begin
              pad_cnt <= pad_cnt + 1'b1;
            end
          end
        end
        S_FIN: begin
          // Stay in FIN through the done cycle so busy covers it and a
          // start coinciding with done is ignored. done is raised once the
          // read stage is empty, i.e. while the last pixel is on the
          // output register, so it lands in the following cycle.
          if (done) begin
            state <= S_IDLE;
          end else if (!s1_valid) begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-stage output pipeline shared by image and pad pixels
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid       <= 1'b0;
      s1_pad         <= 1'b0;
      s1_last        <= 1'b0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
      frame_last     <= 1'b0;
    end else begin
      s1_valid       <= issue;
      s1_pad         <= (state == S_FLUSH);
      s1_last        <= issue_pix && (pix_cnt == PIX_LAST);
      data_valid_out <= s1_valid;
      frame_last     <= s1_valid && s1_last;
      if (s1_valid) begin
        data_out <= s1_pad ? '0 : rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fmap_stream_tx.sv
// tb_fmap_stream_tx
//   Self-checking bench for fmap_stream_tx. Two instances share stimulus:
//   a 4x4 map with 5 pad pixels, and a 4x4 map with no padding. Expected
//   outputs come from a timeline model: the k-th non-stalled cycle after the
//   start cycle issues stream element k, which appears two cycles later; done
//   follows the final element and busy spans start+1 through done.

module tb_fmap_stream_tx;

  localparam int DW   = 32;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PAD  = 5;
  localparam int AW   = 5;
  localparam int NPIX = W * H;
  localparam int NMAX = NPIX + PAD;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          stall;

  logic          busy_p, valid_p, last_p, done_p;
  logic [DW-1:0] data_p;
  logic          busy_z, valid_z, last_z, done_z;
  logic [DW-1:0] data_z;

  always #5 clk = ~clk;

  fmap_stream_tx #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .PAD_PIXELS(PAD), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .stall(stall), .busy(busy_p),
    .data_valid_out(valid_p), .data_out(data_p), .frame_last(last_p),
    .done(done_p)
  );

  fmap_stream_tx #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .PAD_PIXELS(0), .ADDR_WIDTH(AW)
  ) dut_nopad (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .stall(stall), .busy(busy_z),
    .data_valid_out(valid_z), .data_out(data_z), .frame_last(last_z),
    .done(done_z)
  );

  int n_checks;
  int n_fail;

  logic [DW-1:0] ref_mem [NPIX];
  logic [DW-1:0] hold [2];
  bit            stall_pat [256];
  int            out_r [2][NMAX];
  int            n_tot [2];
  int            done_r [2];

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int find_idx(input int i, input int r);
    for (int k = 0; k < n_tot[i]; k++) begin
      if (out_r[i][k] == r) return k;
    end
    return -1;
  endfunction

  task automatic get_obs(input int i, output logic v, output logic [DW-1:0] d,
                         output logic l, output logic dn, output logic b);
    if (i == 0) begin
      v = valid_p; d = data_p; l = last_p; dn = done_p; b = busy_p;
    end else begin
      v = valid_z; d = data_z; l = last_z; dn = done_z; b = busy_z;
    end
  endtask

  task automatic check_inst(input int i, input int r);
    logic v, l, dn, b;
    logic [DW-1:0] d, e;
    int k;
    string nm;
    nm = $sformatf("%s r%0d", (i == 0) ? "pad" : "nopad", r);
    get_obs(i, v, d, l, dn, b);
    k = find_idx(i, r);
    check_val({nm, " valid"}, DW'(v), DW'(k >= 0));
    check_val({nm, " busy"}, DW'(b), DW'(r >= 1 && r <= done_r[i]));
    check_val({nm, " done"}, DW'(dn), DW'(r == done_r[i]));
    if (k >= 0) begin
      e = (k < NPIX) ? ref_mem[k] : '0;
      check_val($sformatf("%s data[%0d]", nm, k), d, e);
      check_val({nm, " last"}, DW'(l), DW'(k == NPIX - 1));
      hold[i] = e;
    end else begin
      check_val({nm, " data_hold"}, d, hold[i]);
      check_val({nm, " last_idle"}, DW'(l), '0);
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    logic v, l, dn, b;
    logic [DW-1:0] d;
    get_obs(i, v, d, l, dn, b);
    check_val({tag, " valid"}, DW'(v), '0);
    check_val({tag, " busy"}, DW'(b), '0);
    check_val({tag, " done"}, DW'(dn), '0);
    check_val({tag, " last"}, DW'(l), '0);
    check_val({tag, " data_hold"}, d, hold[i]);
  endtask

  task automatic check_zero(input string tag);
    hold[0] = '0;
    hold[1] = '0;
    check_idle(0, {tag, " pad"});
    check_idle(1, {tag, " nopad"});
  endtask

  task automatic idle_cycles(input int n, input bit wr_rand);
    int a;
    logic [DW-1:0] d;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_idle(0, "idle pad");
      check_idle(1, "idle nopad");
      start = 1'b0;
      stall = 1'($urandom_range(0, 1));
      wr_en = 1'b0;
      if (wr_rand && $urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 2 * NPIX - 1);
        d = $urandom;
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (a < NPIX) ref_mem[a] = d;
      end
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      check_idle(0, "load pad");
      check_idle(1, "load nopad");
      start   = 1'b0;
      stall   = 1'b0;
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = 32'h3f80_0000 + DW'(i);
      ref_mem[i] = 32'h3f80_0000 + DW'(i);
    end
  endtask

  // mode 0: no stall; 1: 3-cycle stall after the 6th issue; 2: random stall
  // poke: extra start at r=8 and a write to address 2 at r=9 (both busy)
  // abort_k >= 0: reset asserted in the output cycle of element abort_k
  // wr0: write a fresh value to address 0 in the start cycle
  task automatic run_frame(input int mode, input bit poke, input int abort_k,
                           input bit wr0);
    logic [DW-1:0] nv;
    int k;
    for (int r = 0; r < 256; r++) stall_pat[r] = 1'b0;
    if (mode == 1) begin
      for (int r = 7; r <= 9; r++) stall_pat[r] = 1'b1;
    end else if (mode == 2) begin
      for (int r = 1; r <= 100; r++) stall_pat[r] = ($urandom_range(0, 3) == 0);
    end
    n_tot[0] = NPIX + PAD;
    n_tot[1] = NPIX;
    for (int i = 0; i < 2; i++) begin
      k = 0;
      for (int r = 1; r < 256; r++) begin
        if (!stall_pat[r] && k < n_tot[i]) begin
          out_r[i][k] = r + 2;
          k++;
        end
      end
      done_r[i] = out_r[i][n_tot[i] - 1] + 1;
    end
    for (int r = 0; r <= done_r[0]; r++) begin
      @(negedge clk);
      check_inst(0, r);
      check_inst(1, r);
      if (abort_k >= 0 && r == out_r[0][abort_k]) begin
        start  = 1'b0;
        stall  = 1'b0;
        wr_en  = 1'b0;
        resetn = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) begin
          @(negedge clk);
          check_zero("abort hold");
        end
        resetn = 1'b1;
        return;
      end
      start = (r == 0) || (poke && r == 8);
      stall = stall_pat[r];
      wr_en = 1'b0;
      if (r == 0 && wr0) begin
        nv = $urandom;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = nv;
        ref_mem[0] = nv;
      end
      if (poke && r == 9) begin
        wr_en   = 1'b1;
        wr_addr = AW'(2);
        wr_data = 32'hdead_beef;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    hold[0]  = '0;
    hold[1]  = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;

    idle_cycles(2, 1'b0);
    load_ramp();
    idle_cycles(2, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0);

    idle_cycles(3, 1'b0);
    run_frame(1, 1'b0, -1, 1'b0);

    idle_cycles(2, 1'b0);
    run_frame(0, 1'b1, -1, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0);

    idle_cycles(2, 1'b0);
    run_frame(0, 1'b0, 7, 1'b0);
    idle_cycles(3, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0);

    for (int j = 0; j < 8; j++) begin
      idle_cycles($urandom_range(1, 8), 1'b1);
      run_frame(2, 1'b0, -1, 1'($urandom_range(0, 1)));
      if (j % 2 == 1) run_frame(2, 1'b0, -1, 1'b0);
    end
    idle_cycles(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
